// File: rtl/neander_pkg.sv
// Shared types for the Neander control unit: opcodes, ALU selects, FSM states.
package neander_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_STA = 4'h1,
        OP_LDA = 4'h2,
        OP_ADD = 4'h3,
        OP_OR  = 4'h4,
        OP_AND = 4'h5,
        OP_NOT = 4'h6,
        OP_JMP = 4'h8,
        OP_JN  = 4'h9,
        OP_JZ  = 4'hA,
        OP_HLT = 4'hF
    } opcode_t;

    typedef logic [2:0] ula_sel_t;

    localparam ula_sel_t ULA_ADD    = 3'b000;
    localparam ula_sel_t ULA_OR     = 3'b001;
    localparam ula_sel_t ULA_AND    = 3'b010;
    localparam ula_sel_t ULA_NOT    = 3'b011;
    localparam ula_sel_t ULA_PASS_Y = 3'b100;

    typedef enum logic [3:0] {
        S_FETCH_ADDR,
        S_FETCH_WAIT,
        S_FETCH_DATA,
        S_FETCH_IR,
        S_DECODE,
        S_EXEC_ADDR,
        S_EXEC_WAIT,
        S_EXEC_DATA,
        S_EXEC_ALU,
        S_EXEC_STORE,
        S_EXEC_JUMP,
        S_HALT
    } ctrl_state_t;

    // ALU operation used by the accumulator-writing instructions.
    function automatic ula_sel_t ula_for(input logic [3:0] op);
        case (op)
            OP_LDA:  return ULA_PASS_Y;
            OP_ADD:  return ULA_ADD;
            OP_OR:   return ULA_OR;
            OP_AND:  return ULA_AND;
            OP_NOT:  return ULA_NOT;
            default: return ULA_ADD;
        endcase
    endfunction

    // Counter preload so that a wait state lasts exactly lat cycles.
    function automatic logic [2:0] wait_preload(input int lat);
        if (lat <= 0) return 3'd0;
        return 3'(lat - 1);
    endfunction

endpackage

// File: rtl/neander_ctrl_if.sv
// Control-unit <-> datapath bundle: IR opcode and flags in, strobes out.
interface neander_ctrl_if;
    import neander_pkg::*;

    logic [3:0] opcode;
    logic       n_flag;
    logic       z_flag;
    logic       pc_load;
    logic       pc_inc;
    logic       rem_load;
    logic       rdm_load;
    logic       ri_load;
    logic       ac_load;
    logic       n_load;
    logic       z_load;
    logic       mem_write;
    logic       sel_rem;
    ula_sel_t   sel_ula;

    modport master (
        input  opcode, n_flag, z_flag,
        output pc_load, pc_inc, rem_load, rdm_load, ri_load, ac_load,
               n_load, z_load, mem_write, sel_rem, sel_ula
    );

    modport slave (
        output opcode, n_flag, z_flag,
        input  pc_load, pc_inc, rem_load, rdm_load, ri_load, ac_load,
               n_load, z_load, mem_write, sel_rem, sel_ula
    );
endinterface

// File: rtl/neander_wait_cnt.sv
// Loadable 3-bit down-counter that times the memory wait states; saturates at zero.
module neander_wait_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       dec,
    output logic       done
);
    logic [2:0] cnt;

    // Preload on wait-state entry, then count down to zero without wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 3'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != 3'd0)) begin
            cnt <= cnt - 3'd1;
        end
    end

    assign done = (cnt == 3'd0);
endmodule

// File: rtl/neander_ctrl.sv
// Neander multi-cycle control unit: fetch/decode/execute sequencer for the datapath.
// Optional single-step mode is built when the macro CTRL_STEP_EN is defined.
module neander_ctrl
    import neander_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
`ifdef CTRL_STEP_EN
    input  logic           step,
`endif
    neander_ctrl_if.master dp,
    output logic           halted,
    output logic           instr_done
);
    localparam bit         LAT_ZERO     = (MEM_LAT == 0);
    localparam logic [2:0] WAIT_PRELOAD = wait_preload(MEM_LAT);

    ctrl_state_t state, next_state;
    logic        go;
    logic        cnt_load, cnt_dec, cnt_done;
    logic        pc_load, pc_inc, rem_load, rdm_load, ri_load;
    logic        ac_load, n_load, z_load, mem_write, sel_rem;
    ula_sel_t    sel_ula;

`ifdef CTRL_STEP_EN
    logic [2:0] step_sync;
    logic       step_pend;

    // Two-flop synchroniser plus edge history; a pending edge is consumed on leaving fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_sync <= 3'b000;
            step_pend <= 1'b0;
        end else begin
            step_sync <= {step_sync[1:0], step};
            if ((state == S_FETCH_ADDR) && go) begin
                step_pend <= 1'b0;
            end else if (step_sync[1] && !step_sync[2]) begin
                step_pend <= 1'b1;
            end
        end
    end

    assign go = run && step_pend;
`else
    assign go = run;
`endif

    neander_wait_cnt u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (WAIT_PRELOAD),
        .dec      (cnt_dec),
        .done     (cnt_done)
    );

    assign cnt_dec  = (state == S_FETCH_WAIT) || (state == S_EXEC_WAIT);
    assign cnt_load = ((next_state == S_FETCH_WAIT) || (next_state == S_EXEC_WAIT))
                      && (next_state != state);

    // State register; reset aborts any instruction in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH_ADDR;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and strobe decode; one strobe group per state.
    always_comb begin
        next_state = state;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        rem_load   = 1'b0;
        rdm_load   = 1'b0;
        ri_load    = 1'b0;
        ac_load    = 1'b0;
        n_load     = 1'b0;
        z_load     = 1'b0;
        mem_write  = 1'b0;
        sel_rem    = 1'b1;
        sel_ula    = ULA_ADD;
        halted     = 1'b0;
        instr_done = 1'b0;
        case (state)
            S_FETCH_ADDR: begin
                if (go) begin
                    rem_load   = 1'b1;
                    next_state = LAT_ZERO ? S_FETCH_DATA : S_FETCH_WAIT;
                end
            end
            S_FETCH_WAIT: begin
                if (cnt_done) next_state = S_FETCH_DATA;
            end
            S_FETCH_DATA: begin
                rdm_load   = 1'b1;
                pc_inc     = 1'b1;
                next_state = S_FETCH_IR;
            end
            S_FETCH_IR: begin
                ri_load    = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                case (dp.opcode)
                    OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND: next_state = S_EXEC_ADDR;
                    OP_NOT: next_state = S_EXEC_ALU;
                    OP_JMP: next_state = S_EXEC_JUMP;
                    OP_JN: begin
                        if (dp.n_flag) begin
                            next_state = S_EXEC_JUMP;
                        end else begin
                            instr_done = 1'b1;
                            next_state = S_FETCH_ADDR;
                        end
                    end
                    OP_JZ: begin
                        if (dp.z_flag) begin
                            next_state = S_EXEC_JUMP;
                        end else begin
                            instr_done = 1'b1;
                            next_state = S_FETCH_ADDR;
                        end
                    end
                    OP_HLT: next_state = S_HALT;
                    default: begin
                        instr_done = 1'b1;
                        next_state = S_FETCH_ADDR;
                    end
                endcase
            end
            S_EXEC_ADDR: begin
                rem_load = 1'b1;
                sel_rem  = 1'b0;
                if (dp.opcode == OP_STA) begin
                    next_state = S_EXEC_STORE;
                end else begin
                    next_state = LAT_ZERO ? S_EXEC_DATA : S_EXEC_WAIT;
                end
            end
            S_EXEC_WAIT: begin
                if (cnt_done) next_state = S_EXEC_DATA;
            end
            S_EXEC_DATA: begin
                rdm_load   = 1'b1;
                next_state = S_EXEC_ALU;
            end
            S_EXEC_ALU: begin
                ac_load    = 1'b1;
                n_load     = 1'b1;
                z_load     = 1'b1;
                sel_ula    = ula_for(dp.opcode);
                instr_done = 1'b1;
                next_state = S_FETCH_ADDR;
            end
            S_EXEC_STORE: begin
                mem_write  = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH_ADDR;
            end
            S_EXEC_JUMP: begin
                pc_load    = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH_ADDR;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: next_state = S_FETCH_ADDR;
        endcase
        // While reset is held the fetch state must not leak a run-gated rem_load.
        if (rst) begin
            rem_load = 1'b0;
        end
    end

    assign dp.pc_load   = pc_load;
    assign dp.pc_inc    = pc_inc;
    assign dp.rem_load  = rem_load;
    assign dp.rdm_load  = rdm_load;
    assign dp.ri_load   = ri_load;
    assign dp.ac_load   = ac_load;
    assign dp.n_load    = n_load;
    assign dp.z_load    = z_load;
    assign dp.mem_write = mem_write;
    assign dp.sel_rem   = sel_rem;
    assign dp.sel_ula   = sel_ula;
endmodule

// File: tb/tb_neander_ctrl.sv
// Bench for neander_ctrl: per-instruction strobe traces built from the instruction
// timing rules, compared cycle by cycle for MEM_LAT = 1 and MEM_LAT = 3 instances.
module tb_neander_ctrl;
    localparam logic [14:0] B_PCL  = 15'h0001;
    localparam logic [14:0] B_PCI  = 15'h0002;
    localparam logic [14:0] B_REM  = 15'h0004;
    localparam logic [14:0] B_RDM  = 15'h0008;
    localparam logic [14:0] B_RI   = 15'h0010;
    localparam logic [14:0] B_AC   = 15'h0020;
    localparam logic [14:0] B_N    = 15'h0040;
    localparam logic [14:0] B_Z    = 15'h0080;
    localparam logic [14:0] B_MW   = 15'h0100;
    localparam logic [14:0] B_SREM = 15'h0200;
    localparam logic [14:0] B_DONE = 15'h2000;
    localparam logic [14:0] B_HALT = 15'h4000;
    localparam logic [14:0] IDLE   = B_SREM;

    logic clk = 1'b0;
    logic rst;
    logic run1, run3;
    logic halted1, halted3, done1, done3;
    logic use3;
    int   checks = 0;
    int   errors = 0;
    logic [14:0] q[$];
    logic [14:0] v1, v3;

    always #5 clk = ~clk;

    neander_ctrl_if i1 ();
    neander_ctrl_if i3 ();

`ifdef CTRL_STEP_EN
    logic step1, step3;
    neander_ctrl #(.MEM_LAT(1)) dut1 (.clk(clk), .rst(rst), .run(run1), .step(step1),
                                      .dp(i1.master), .halted(halted1), .instr_done(done1));
    neander_ctrl #(.MEM_LAT(3)) dut3 (.clk(clk), .rst(rst), .run(run3), .step(step3),
                                      .dp(i3.master), .halted(halted3), .instr_done(done3));
`else
    neander_ctrl #(.MEM_LAT(1)) dut1 (.clk(clk), .rst(rst), .run(run1),
                                      .dp(i1.master), .halted(halted1), .instr_done(done1));
    neander_ctrl #(.MEM_LAT(3)) dut3 (.clk(clk), .rst(rst), .run(run3),
                                      .dp(i3.master), .halted(halted3), .instr_done(done3));
`endif

    assign v1 = {halted1, done1, i1.sel_ula, i1.sel_rem, i1.mem_write, i1.z_load, i1.n_load,
                 i1.ac_load, i1.ri_load, i1.rdm_load, i1.rem_load, i1.pc_inc, i1.pc_load};
    assign v3 = {halted3, done3, i3.sel_ula, i3.sel_rem, i3.mem_write, i3.z_load, i3.n_load,
                 i3.ac_load, i3.ri_load, i3.rdm_load, i3.rem_load, i3.pc_inc, i3.pc_load};

    function automatic logic [14:0] obs();
        return use3 ? v3 : v1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Accumulator-writing cycle: loads AC/N/Z with the instruction's ALU op.
    function automatic logic [14:0] alu_vec(input logic [3:0] op);
        logic [2:0] u;
        case (op)
            4'h2:    u = 3'b100;
            4'h3:    u = 3'b000;
            4'h4:    u = 3'b001;
            4'h5:    u = 3'b010;
            default: u = 3'b011;
        endcase
        return IDLE | B_AC | B_N | B_Z | B_DONE | {2'b00, u, 10'b0};
    endfunction

    // Expected per-cycle outputs of one instruction, starting at its fetch cycle.
    task automatic build(input logic [3:0] op, input logic n, input logic z, input int lat);
        q.delete();
        q.push_back(IDLE | B_REM);
        for (int i = 0; i < lat; i++) q.push_back(IDLE);
        q.push_back(IDLE | B_RDM | B_PCI);
        q.push_back(IDLE | B_RI);
        case (op)
            4'h1: begin
                q.push_back(IDLE);
                q.push_back(B_REM);
                q.push_back(IDLE | B_MW | B_DONE);
            end
            4'h2, 4'h3, 4'h4, 4'h5: begin
                q.push_back(IDLE);
                q.push_back(B_REM);
                for (int i = 0; i < lat; i++) q.push_back(IDLE);
                q.push_back(IDLE | B_RDM);
                q.push_back(alu_vec(op));
            end
            4'h6: begin
                q.push_back(IDLE);
                q.push_back(alu_vec(op));
            end
            4'h8: begin
                q.push_back(IDLE);
                q.push_back(IDLE | B_PCL | B_DONE);
            end
            4'h9, 4'hA: begin
                if ((op == 4'h9) ? n : z) begin
                    q.push_back(IDLE);
                    q.push_back(IDLE | B_PCL | B_DONE);
                end else begin
                    q.push_back(IDLE | B_DONE);
                end
            end
            4'hF: begin
                q.push_back(IDLE);
                for (int i = 0; i < 20; i++) q.push_back(IDLE | B_HALT);
            end
            default: q.push_back(IDLE | B_DONE);
        endcase
    endtask

    // Called on a falling edge; leaves the bench on the first falling edge after release.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_out", 32'(obs()), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Entered on the falling edge of the instruction's first cycle; exits on the next one.
    task automatic run_instr(input logic [3:0] op, input logic n, input logic z, input int abort_at);
        int lat;
        lat = use3 ? 3 : 1;
        i1.opcode = op; i1.n_flag = n; i1.z_flag = z;
        i3.opcode = op; i3.n_flag = n; i3.z_flag = z;
        build(op, n, z, lat);
`ifdef CTRL_STEP_EN
        begin
            logic        found;
            logic [14:0] cur;
            found = 1'b0;
            #1;
            check_eq("step_hold", 32'(obs()), 32'(IDLE));
            if (use3) step3 = 1'b1; else step1 = 1'b1;
            repeat (2) @(negedge clk);
            step1 = 1'b0;
            step3 = 1'b0;
            for (int k = 0; k < 12 && !found; k++) begin
                #1;
                cur = obs();
                if (cur[2]) found = 1'b1;
                else @(negedge clk);
            end
            check_eq("step_start", 32'(found), 32'd1);
        end
`endif
        for (int j = 0; j < q.size(); j++) begin
            if (j > 0) @(negedge clk);
            #1;
            check_eq($sformatf("op%h_n%0d_z%0d_cyc%0d", op, n, z, j), 32'(obs()), 32'(q[j]));
            if (j == abort_at) begin
                rst = 1'b1;
                #1;
                check_eq("abort_rst", 32'(obs()), 32'(IDLE));
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
        @(negedge clk);
        if (op == 4'hF) do_reset();
    endtask

    initial begin
        rst  = 1'b1;
        run1 = 1'b1;
        run3 = 1'b0;
        use3 = 1'b0;
        i1.opcode = 4'h0; i1.n_flag = 1'b0; i1.z_flag = 1'b0;
        i3.opcode = 4'h0; i3.n_flag = 1'b0; i3.z_flag = 1'b0;
`ifdef CTRL_STEP_EN
        step1 = 1'b0;
        step3 = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_hold", 32'(obs()), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;

        // Directed instructions at MEM_LAT = 1.
        run_instr(4'h2, 1'b0, 1'b0, -1);
        run_instr(4'h1, 1'b0, 1'b0, -1);
        run_instr(4'h9, 1'b1, 1'b0, -1);
        run_instr(4'h9, 1'b0, 1'b1, -1);
        run_instr(4'hA, 1'b0, 1'b1, -1);
        run_instr(4'hA, 1'b1, 1'b0, -1);
        run_instr(4'h6, 1'b0, 1'b0, -1);
        run_instr(4'h8, 1'b0, 1'b0, -1);
        run_instr(4'h0, 1'b0, 1'b0, -1);
        run_instr(4'h7, 1'b0, 1'b0, -1);
        run_instr(4'hF, 1'b0, 1'b0, -1);

        // run low holds fetch idle; raising it starts fetch at once.
        run1 = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq("run_low_idle", 32'(obs()), 32'(IDLE));
            @(negedge clk);
        end
        run1 = 1'b1;
        run_instr(4'h0, 1'b0, 1'b0, -1);

        // Reset during the operand read of an LDA.
        run_instr(4'h2, 1'b0, 1'b0, 7);
        run_instr(4'h3, 1'b0, 1'b0, -1);

        for (int i = 0; i < 30; i++) begin
            run_instr(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), -1);
        end

        // Same checks against the MEM_LAT = 3 instance.
        run1 = 1'b0;
        use3 = 1'b1;
        run3 = 1'b1;
        do_reset();
        run_instr(4'h2, 1'b0, 1'b0, -1);
        run_instr(4'h1, 1'b0, 1'b0, -1);
        run_instr(4'h6, 1'b0, 1'b0, -1);
        run_instr(4'hF, 1'b0, 1'b0, -1);
        for (int i = 0; i < 15; i++) begin
            run_instr(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
